// File: rtl/csr_commit_unit_if.sv
// MEM-to-commit instruction handshake: one instruction moves per in_valid && in_ready beat.
interface csr_commit_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [3:0]  in_op;
  logic [13:0] in_csr_num;
  logic [31:0] in_rj_val;
  logic [31:0] in_rd_val;
  logic [31:0] in_result;
  logic        in_rf_we;
  logic [4:0]  in_rd_addr;
  logic        in_exc_valid;
  logic [5:0]  in_exc_ecode;
  logic [8:0]  in_exc_esubcode;
  logic [31:0] in_vaddr;

  modport master (
    output in_valid, in_pc, in_op, in_csr_num, in_rj_val, in_rd_val, in_result,
           in_rf_we, in_rd_addr, in_exc_valid, in_exc_ecode, in_exc_esubcode, in_vaddr,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pc, in_op, in_csr_num, in_rj_val, in_rd_val, in_result,
           in_rf_we, in_rd_addr, in_exc_valid, in_exc_ecode, in_exc_esubcode, in_vaddr,
    output in_ready
  );
endinterface

// File: rtl/csr_commit_unit.sv
// Commit stage: CSR access, GPR writeback, exception/ERTN/refetch redirect with flush held until ack.
// Commits one cycle after acceptance; stalls input only while a flushing instruction is held.
module csr_commit_unit #(
  parameter bit REFETCH_ON_CSRWR = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  csr_commit_unit_if.slave mem,
  output logic [13:0]      csr_addr,
  output logic [31:0]      csr_wdata,
  output logic [31:0]      csr_wmask,
  output logic             csr_we,
  output logic             ertn_flush,
  output logic             wb_exception,
  output logic [5:0]       wb_ecode,
  output logic [8:0]       wb_esubcode,
  output logic [31:0]      wb_vaddr,
  output logic [31:0]      wb_pc,
  input  logic [31:0]      csr_rdata,
  input  logic [31:0]      exception_entry,
  input  logic [31:0]      exception_return_entry,
  input  logic             interrupt,
  input  logic [63:0]      timer,
  input  logic [31:0]      timer_id,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ack
);
  localparam logic [3:0] OP_NONE = 4'd0, OP_CSRRD = 4'd1, OP_CSRWR = 4'd2, OP_CSRXCHG = 4'd3,
                         OP_ERTN = 4'd4, OP_SYSCALL = 4'd5, OP_BREAK = 4'd6,
                         OP_RDCNTVL = 4'd7, OP_RDCNTVH = 4'd8, OP_RDCNTID = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REDIRECT} state_t;
  state_t r_state, w_state_nxt;

  logic [31:0] r_pc, r_rj_val, r_rd_val, r_result, r_vaddr;
  logic [3:0]  r_op;
  logic [13:0] r_csr_num;
  logic        r_rf_we, r_exc_valid;
  logic [4:0]  r_rd_addr;
  logic [5:0]  r_exc_ecode;
  logic [8:0]  r_exc_esubcode;

  logic w_hold, w_intr, w_upexc, w_sys, w_exc, w_ertn, w_normal, w_csr_wr;
  logic w_refetch_csr, w_refetch, w_flush, w_gpr_op, w_rf_we, w_accept;

  // Commit priority: interrupt, upstream exception, syscall/break, ertn, normal op.
  assign w_hold        = (r_state == S_HOLD);
  assign w_intr        = w_hold & interrupt;
  assign w_upexc       = w_hold & ~interrupt & r_exc_valid;
  assign w_sys         = w_hold & ~interrupt & ~r_exc_valid & ((r_op == OP_SYSCALL) | (r_op == OP_BREAK));
  assign w_exc         = w_intr | w_upexc | w_sys;
  assign w_ertn        = w_hold & ~w_exc & (r_op == OP_ERTN);
  assign w_normal      = w_hold & ~w_exc & ~w_ertn;
  assign w_csr_wr      = w_normal & ((r_op == OP_CSRWR) | (r_op == OP_CSRXCHG));
  assign w_refetch_csr = (r_csr_num == 14'h0) | (r_csr_num == 14'h4) |
                         (r_csr_num == 14'h5) | (r_csr_num == 14'h44);
  assign w_refetch     = REFETCH_ON_CSRWR & w_csr_wr & w_refetch_csr;
  assign w_flush       = w_exc | w_ertn | w_refetch;
  assign w_gpr_op      = (r_op == OP_CSRRD) | (r_op == OP_CSRWR) | (r_op == OP_CSRXCHG) |
                         (r_op == OP_RDCNTVL) | (r_op == OP_RDCNTVH) | (r_op == OP_RDCNTID) |
                         ((r_op == OP_NONE) & r_rf_we);
  assign w_rf_we       = w_normal & w_gpr_op & (r_rd_addr != 5'd0);

  // Beats taken during REDIRECT are handshaken but discarded.
  assign mem.in_ready  = ~w_hold | ~w_flush;
  assign w_accept      = mem.in_valid & mem.in_ready & (r_state != S_REDIRECT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      redirect_pc    <= 32'd0;
      r_pc           <= 32'd0;
      r_op           <= OP_NONE;
      r_csr_num      <= 14'd0;
      r_rj_val       <= 32'd0;
      r_rd_val       <= 32'd0;
      r_result       <= 32'd0;
      r_rf_we        <= 1'b0;
      r_rd_addr      <= 5'd0;
      r_exc_valid    <= 1'b0;
      r_exc_ecode    <= 6'd0;
      r_exc_esubcode <= 9'd0;
      r_vaddr        <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_exc)          redirect_pc <= exception_entry;
      else if (w_ertn)    redirect_pc <= exception_return_entry;
      else if (w_refetch) redirect_pc <= r_pc + 32'd4;
      if (w_accept) begin
        r_pc           <= mem.in_pc;
        r_op           <= mem.in_op;
        r_csr_num      <= mem.in_csr_num;
        r_rj_val       <= mem.in_rj_val;
        r_rd_val       <= mem.in_rd_val;
        r_result       <= mem.in_result;
        r_rf_we        <= mem.in_rf_we;
        r_rd_addr      <= mem.in_rd_addr;
        r_exc_valid    <= mem.in_exc_valid;
        r_exc_ecode    <= mem.in_exc_ecode;
        r_exc_esubcode <= mem.in_exc_esubcode;
        r_vaddr        <= mem.in_vaddr;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    csr_addr       = 14'd0;
    csr_wdata      = 32'd0;
    csr_wmask      = 32'd0;
    csr_we         = 1'b0;
    ertn_flush     = 1'b0;
    wb_exception   = 1'b0;
    wb_ecode       = 6'd0;
    wb_esubcode    = 9'd0;
    wb_vaddr       = 32'd0;
    wb_pc          = 32'd0;
    rf_we          = 1'b0;
    rf_waddr       = 5'd0;
    rf_wdata       = 32'd0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_HOLD;
      S_HOLD: begin
        csr_addr     = r_csr_num;
        wb_exception = w_exc;
        ertn_flush   = w_ertn;
        csr_we       = w_csr_wr;
        rf_we        = w_rf_we;
        if (w_exc) wb_pc = r_pc;
        if (w_upexc) begin
          wb_ecode    = r_exc_ecode;
          wb_esubcode = r_exc_esubcode;
          wb_vaddr    = r_vaddr;
        end else if (w_sys) begin
          wb_ecode = (r_op == OP_BREAK) ? 6'h0C : 6'h0B;
        end
        if (w_csr_wr) begin
          csr_wdata = r_rd_val;
          csr_wmask = (r_op == OP_CSRXCHG) ? r_rj_val : 32'hFFFF_FFFF;
        end
        if (w_rf_we) begin
          rf_waddr = r_rd_addr;
          case (r_op)
            OP_RDCNTVL: rf_wdata = timer[31:0];
            OP_RDCNTVH: rf_wdata = timer[63:32];
            OP_RDCNTID: rf_wdata = timer_id;
            OP_NONE:    rf_wdata = r_result;
            default:    rf_wdata = csr_rdata;
          endcase
        end
        if (w_flush)       w_state_nxt = S_REDIRECT;
        else if (w_accept) w_state_nxt = S_HOLD;
        else               w_state_nxt = S_IDLE;
      end
      S_REDIRECT: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        if (redirect_ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_csr_commit_unit.sv
// Bench for csr_commit_unit: directed scenarios plus randomized commits against a rule-level model.
module tb_csr_commit_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] csr_addr;
  logic [31:0] csr_wdata, csr_wmask, wb_vaddr, wb_pc, rf_wdata, redirect_pc;
  logic        csr_we, ertn_flush, wb_exception, rf_we, flush, redirect_valid;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [4:0]  rf_waddr;
  logic [31:0] csr_rdata = 32'd0, exception_entry = 32'd0, exception_return_entry = 32'd0;
  logic [31:0] timer_id = 32'd0;
  logic [63:0] timer = 64'd0;
  logic        interrupt = 1'b0, redirect_ack = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  csr_commit_unit_if mem();

  csr_commit_unit #(.REFETCH_ON_CSRWR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .mem(mem),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_wmask(csr_wmask), .csr_we(csr_we),
    .ertn_flush(ertn_flush), .wb_exception(wb_exception), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .wb_vaddr(wb_vaddr), .wb_pc(wb_pc), .csr_rdata(csr_rdata),
    .exception_entry(exception_entry), .exception_return_entry(exception_return_entry),
    .interrupt(interrupt), .timer(timer), .timer_id(timer_id), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ack(redirect_ack)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] op, input logic [31:0] pc, input logic [13:0] csr,
                      input logic [31:0] rj, input logic [31:0] rdv, input logic [31:0] res,
                      input logic rfwe, input logic [4:0] rda, input logic exc,
                      input logic [5:0] ec, input logic [8:0] es, input logic [31:0] va);
    mem.in_valid = 1'b1;  mem.in_op = op;        mem.in_pc = pc;       mem.in_csr_num = csr;
    mem.in_rj_val = rj;   mem.in_rd_val = rdv;   mem.in_result = res;  mem.in_rf_we = rfwe;
    mem.in_rd_addr = rda; mem.in_exc_valid = exc; mem.in_exc_ecode = ec;
    mem.in_exc_esubcode = es; mem.in_vaddr = va;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem.in_ready, flush, redirect_valid, csr_we, ertn_flush, wb_exception, rf_we} !== 7'b1000000) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=1000000",
        {mem.in_ready, flush, redirect_valid, csr_we, ertn_flush, wb_exception, rf_we});
    end
    checks++;
    if (redirect_pc !== 32'd0) begin failures++; $display("FAIL reset_redirect_pc got=%h exp=0", redirect_pc); end
  endtask

  task automatic test_csrxchg();
    csr_rdata = 32'h1234_5678;
    beat(4'd3, 32'h1C00_0010, 14'h30, 32'h0000_FFFF, 32'hAAAA_5555, 32'd0, 1'b0, 5'd5, 1'b0, 6'd0, 9'd0, 32'd0);
    step();
    mem.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({csr_we, csr_addr, csr_wmask, csr_wdata} !== {1'b1, 14'h30, 32'h0000_FFFF, 32'hAAAA_5555}) begin
      failures++; $display("FAIL xchg_csr got=%b/%h/%h/%h exp=1/0030/0000ffff/aaaa5555", csr_we, csr_addr, csr_wmask, csr_wdata);
    end
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h1234_5678}) begin
      failures++; $display("FAIL xchg_rf got=%b/%0d/%h exp=1/5/12345678", rf_we, rf_waddr, rf_wdata);
    end
    step();
    @(negedge clk);
    checks++;
    if ({csr_we, flush, redirect_valid} !== 3'b000) begin
      failures++; $display("FAIL xchg_after got=%b exp=000", {csr_we, flush, redirect_valid});
    end
  endtask

  task automatic test_syscall();
    int nflush;
    nflush = 0;
    exception_entry = 32'h1C00_8000;
    beat(4'd5, 32'h1C00_0100, 14'h0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd3, 1'b0, 6'd0, 9'd0, 32'd0);
    step();
    mem.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({wb_exception, wb_ecode, wb_pc, rf_we, csr_we} !== {1'b1, 6'h0B, 32'h1C00_0100, 2'b00}) begin
      failures++; $display("FAIL syscall_commit got=%b/%h/%h/%b%b exp=1/0b/1c000100/00",
        wb_exception, wb_ecode, wb_pc, rf_we, csr_we);
    end
    step();
    for (int c = 1; c <= 5; c++) begin
      if (c == 3) redirect_ack = 1'b1;
      @(negedge clk);
      if (flush) nflush++;
      if (c == 1) begin
        checks++;
        if ({redirect_valid, redirect_pc} !== {1'b1, 32'h1C00_8000}) begin
          failures++; $display("FAIL syscall_redirect got=%b/%h exp=1/1c008000", redirect_valid, redirect_pc);
        end
      end
      step();
      redirect_ack = 1'b0;
    end
    checks++;
    if (nflush != 3) begin failures++; $display("FAIL syscall_flush_len got=%0d exp=3", nflush); end
  endtask

  task automatic test_ertn();
    exception_return_entry = 32'h1C00_0104;
    beat(4'd4, 32'h1C00_0050, 14'h6, 32'd0, 32'd0, 32'd0, 1'b1, 5'd7, 1'b0, 6'd0, 9'd0, 32'd0);
    step();
    mem.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({ertn_flush, wb_exception, csr_we, rf_we} !== 4'b1000) begin
      failures++; $display("FAIL ertn_commit got=%b exp=1000", {ertn_flush, wb_exception, csr_we, rf_we});
    end
    step();
    exception_return_entry = 32'hDEAD_0000;
    redirect_ack = 1'b1;
    @(negedge clk);
    checks++;
    if ({flush, ertn_flush, redirect_pc} !== {2'b10, 32'h1C00_0104}) begin
      failures++; $display("FAIL ertn_redirect got=%b%b/%h exp=10/1c000104", flush, ertn_flush, redirect_pc);
    end
    step();
    redirect_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (flush !== 1'b0) begin failures++; $display("FAIL ertn_one_cycle got=%b exp=0", flush); end
  endtask

  task automatic test_reset_mid_redirect();
    beat(4'd4, 32'h1C00_0060, 14'h0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0, 9'd0, 32'd0);
    step();
    mem.in_valid = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if (flush !== 1'b1) begin failures++; $display("FAIL midrst_pre got=%b exp=1", flush); end
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({flush, redirect_valid, csr_we, ertn_flush, wb_exception, mem.in_ready} !== 6'b000001) begin
      failures++; $display("FAIL midrst_post got=%b exp=000001",
        {flush, redirect_valid, csr_we, ertn_flush, wb_exception, mem.in_ready});
    end
  endtask

  task automatic test_interrupt();
    exception_entry = 32'h1C00_9000;
    interrupt = 1'b1;
    beat(4'd0, 32'h1C00_0200, 14'h0, 32'd0, 32'd0, 32'h5555_0000, 1'b1, 5'd9, 1'b0, 6'd0, 9'd0, 32'd0);
    step();
    mem.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({wb_exception, wb_ecode, wb_esubcode, wb_pc, rf_we} !== {1'b1, 6'h00, 9'h000, 32'h1C00_0200, 1'b0}) begin
      failures++; $display("FAIL intr_commit got=%b/%h/%h/%h/%b exp=1/00/000/1c000200/0",
        wb_exception, wb_ecode, wb_esubcode, wb_pc, rf_we);
    end
    step();
    interrupt = 1'b0;
    beat(4'd2, 32'h1C00_0300, 14'h4, 32'd0, 32'h7777_7777, 32'd0, 1'b0, 5'd3, 1'b0, 6'd0, 9'd0, 32'd0);
    @(negedge clk);
    checks++;
    if ({mem.in_ready, flush} !== 2'b11) begin
      failures++; $display("FAIL intr_redirect_ready got=%b exp=11", {mem.in_ready, flush});
    end
    step();
    mem.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({flush, csr_we, rf_we} !== 3'b100) begin
      failures++; $display("FAIL intr_drop_a got=%b exp=100", {flush, csr_we, rf_we});
    end
    redirect_ack = 1'b1;
    step();
    redirect_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({flush, csr_we, rf_we, redirect_pc} !== {3'b000, 32'h1C00_9000}) begin
      failures++; $display("FAIL intr_drop_b got=%b/%h exp=000/1c009000", {flush, csr_we, rf_we}, redirect_pc);
    end
  endtask

  task automatic test_back_to_back();
    timer = 64'h0000_0001_FFFF_FFFF;
    beat(4'd7, 32'h1C00_0400, 14'h0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd4, 1'b0, 6'd0, 9'd0, 32'd0);
    step();
    beat(4'd8, 32'h1C00_0404, 14'h0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd6, 1'b0, 6'd0, 9'd0, 32'd0);
    @(negedge clk);
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, mem.in_ready} !== {1'b1, 5'd4, 32'hFFFF_FFFF, 1'b1}) begin
      failures++; $display("FAIL b2b_first got=%b/%0d/%h/%b exp=1/4/ffffffff/1", rf_we, rf_waddr, rf_wdata, mem.in_ready);
    end
    step();
    mem.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, mem.in_ready} !== {1'b1, 5'd6, 32'h0000_0001, 1'b1}) begin
      failures++; $display("FAIL b2b_second got=%b/%0d/%h/%b exp=1/6/00000001/1", rf_we, rf_waddr, rf_wdata, mem.in_ready);
    end
    step();
    beat(4'd2, 32'h0000_0100, 14'h4, 32'd0, 32'h0000_0001, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0, 9'd0, 32'd0);
    step();
    mem.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({csr_we, mem.in_ready} !== 2'b10) begin
      failures++; $display("FAIL refetch_commit got=%b exp=10", {csr_we, mem.in_ready});
    end
    step();
    redirect_ack = 1'b1;
    @(negedge clk);
    checks++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 32'h0000_0104}) begin
      failures++; $display("FAIL refetch_target got=%b/%h exp=1/00000104", redirect_valid, redirect_pc);
    end
    step();
    redirect_ack = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] pc, rj, rdv, res, va, rdata, ee, era, tid;
    logic [13:0] csr;
    logic [4:0]  rda;
    logic [5:0]  ec;
    logic [8:0]  es;
    logic [63:0] tm;
    logic        rfwe, exc, intr;
    logic        e_exc, e_ertn, e_csrwe, e_rfwe, e_flush;
    logic [5:0]  e_ec;
    logic [8:0]  e_es;
    logic [31:0] e_wmask, e_wdata, e_rfdata, e_tgt;
    int          d;
    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom_range(0, 9));
      case ($urandom_range(0, 5))
        0: csr = 14'h0;
        1: csr = 14'h4;
        2: csr = 14'h5;
        3: csr = 14'h44;
        default: csr = 14'($urandom);
      endcase
      pc = $urandom; rj = $urandom; rdv = $urandom; res = $urandom; va = $urandom;
      rdata = $urandom; ee = $urandom; era = $urandom; tid = $urandom; tm = {$urandom, $urandom};
      rda = 5'($urandom); ec = 6'($urandom); es = 9'($urandom); rfwe = 1'($urandom);
      intr = ($urandom_range(0, 9) == 0);
      exc = ($urandom_range(0, 7) == 0);

      e_exc = 1'b0; e_ertn = 1'b0; e_csrwe = 1'b0; e_rfwe = 1'b0; e_flush = 1'b0;
      e_ec = 6'd0; e_es = 9'd0; e_wmask = 32'd0; e_wdata = 32'd0; e_rfdata = 32'd0; e_tgt = 32'd0;
      if (intr) e_exc = 1'b1;
      else if (exc) begin e_exc = 1'b1; e_ec = ec; e_es = es; end
      else if (op == 4'd5) begin e_exc = 1'b1; e_ec = 6'h0B; end
      else if (op == 4'd6) begin e_exc = 1'b1; e_ec = 6'h0C; end
      else if (op == 4'd4) e_ertn = 1'b1;
      else begin
        case (op)
          4'd0: begin e_rfwe = rfwe; e_rfdata = res; end
          4'd1: begin e_rfwe = 1'b1; e_rfdata = rdata; end
          4'd2, 4'd3: begin
            e_rfwe = 1'b1; e_rfdata = rdata; e_csrwe = 1'b1; e_wdata = rdv;
            e_wmask = (op == 4'd3) ? rj : 32'hFFFF_FFFF;
            if (csr == 14'h0 || csr == 14'h4 || csr == 14'h5 || csr == 14'h44) begin
              e_flush = 1'b1; e_tgt = pc + 32'd4;
            end
          end
          4'd7: begin e_rfwe = 1'b1; e_rfdata = tm[31:0]; end
          4'd8: begin e_rfwe = 1'b1; e_rfdata = tm[63:32]; end
          default: begin e_rfwe = 1'b1; e_rfdata = tid; end
        endcase
        if (rda == 5'd0) e_rfwe = 1'b0;
      end
      if (e_exc) begin e_flush = 1'b1; e_tgt = ee; end
      if (e_ertn) begin e_flush = 1'b1; e_tgt = era; end

      csr_rdata = rdata; timer = tm; timer_id = tid; exception_entry = ee;
      exception_return_entry = era; interrupt = intr;
      beat(op, pc, csr, rj, rdv, res, rfwe, rda, exc, ec, es, va);
      step();
      mem.in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({wb_exception, wb_ecode, wb_esubcode, ertn_flush, csr_we, rf_we, csr_addr, mem.in_ready, flush} !==
          {e_exc, e_ec, e_es, e_ertn, e_csrwe, e_rfwe, csr, ~e_flush, 1'b0}) begin
        failures++; $display("FAIL rnd_ctrl n=%0d op=%0d got=%b/%h/%h/%b%b%b/%h/%b exp=%b/%h/%h/%b%b%b/%h/%b", n, op,
          wb_exception, wb_ecode, wb_esubcode, ertn_flush, csr_we, rf_we, csr_addr, mem.in_ready,
          e_exc, e_ec, e_es, e_ertn, e_csrwe, e_rfwe, csr, ~e_flush);
      end
      if (e_exc) begin
        checks++;
        if (wb_pc !== pc) begin failures++; $display("FAIL rnd_wb_pc n=%0d got=%h exp=%h", n, wb_pc, pc); end
        if (exc && !intr) begin
          checks++;
          if (wb_vaddr !== va) begin failures++; $display("FAIL rnd_vaddr n=%0d got=%h exp=%h", n, wb_vaddr, va); end
        end
      end
      if (e_csrwe) begin
        checks++;
        if ({csr_wmask, csr_wdata} !== {e_wmask, e_wdata}) begin
          failures++; $display("FAIL rnd_csr n=%0d got=%h/%h exp=%h/%h", n, csr_wmask, csr_wdata, e_wmask, e_wdata);
        end
      end
      if (e_rfwe) begin
        checks++;
        if ({rf_waddr, rf_wdata} !== {rda, e_rfdata}) begin
          failures++; $display("FAIL rnd_rf n=%0d got=%0d/%h exp=%0d/%h", n, rf_waddr, rf_wdata, rda, e_rfdata);
        end
      end
      step();
      interrupt = 1'b0;
      if (e_flush) begin
        d = $urandom_range(0, 3);
        for (int c = 0; c <= d; c++) begin
          if (c == d) redirect_ack = 1'b1;
          @(negedge clk);
          checks++;
          if ({flush, redirect_valid, redirect_pc} !== {2'b11, e_tgt}) begin
            failures++; $display("FAIL rnd_redirect n=%0d c=%0d got=%b%b/%h exp=11/%h", n, c, flush, redirect_valid, redirect_pc, e_tgt);
          end
          step();
          redirect_ack = 1'b0;
        end
      end
      @(negedge clk);
      checks++;
      if ({flush, redirect_valid, csr_we, rf_we, wb_exception, mem.in_ready} !== 6'b000001) begin
        failures++; $display("FAIL rnd_idle n=%0d got=%b exp=000001", n,
          {flush, redirect_valid, csr_we, rf_we, wb_exception, mem.in_ready});
      end
    end
  endtask

  initial begin
    beat(4'd0, 32'd0, 14'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0, 9'd0, 32'd0);
    mem.in_valid = 1'b0;
    test_reset();
    test_csrxchg();
    test_syscall();
    test_ertn();
    test_reset_mid_redirect();
    test_interrupt();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
